// File: rtl/tc_timer_if.sv
// Bus-side signals of the tc_timer peripheral: bridge register access plus IRQ to CP0.
interface tc_timer_if;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    modport master (output Addr, WE, Din, input Dout, IRQ);
    modport slave  (input Addr, WE, Din, output Dout, IRQ);
endinterface

// File: rtl/tc_timer.sv
// Memory-mapped countdown timer raising a (maskable) interrupt request toward CP0.
// Optional feature macro: TC_AUTO_RELOAD_EN enables Mode 01 auto-reload; otherwise Mode 01 is one-shot.
module tc_timer (
    input  logic       clk,
    input  logic       reset,
    tc_timer_if.slave  bus
);
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t          state;
    logic [CW-1:0]   ctrl;
    logic [DW-1:0]   preset;
    logic [DW-1:0]   count;
    logic            irq_flag;

    logic            wr_ctrl_c;
    logic            wr_preset_c;
    logic            reload_c;

    assign wr_ctrl_c   = bus.WE && (bus.Addr == 2'd0);
    assign wr_preset_c = bus.WE && (bus.Addr == 2'd1);

    // Mode 01 reloads only when the feature is built in; 10/11 always behave as one-shot.
`ifdef TC_AUTO_RELOAD_EN
    assign reload_c = (ctrl[2:1] == 2'b01);
`else
    assign reload_c = 1'b0;
`endif

    // FSM, counter and register file. Software writes are applied after the
    // FSM updates so they take priority over En clear and irq_flag set/hold.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            ctrl     <= '0;
            preset   <= '0;
            count    <= '0;
            irq_flag <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ctrl[0]) state <= LOAD;
                end
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!ctrl[0]) begin
                        state <= IDLE;
                    end else if (count > DW'(1)) begin
                        count <= count - DW'(1);
                    end else begin
                        // PRESET of 0 or 1 both terminate here without wrapping
                        count    <= '0;
                        irq_flag <= 1'b1;
                        state    <= INT;
                    end
                end
                INT: begin
                    if (reload_c) begin
                        irq_flag <= 1'b0;
                        state    <= LOAD;
                    end else begin
                        ctrl[0] <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (wr_ctrl_c)   ctrl   <= bus.Din[CW-1:0];
            if (wr_preset_c) preset <= bus.Din;
            if (wr_ctrl_c || wr_preset_c) irq_flag <= 1'b0;
        end
    end

    // Zero-latency register read mux.
    always_comb begin
        bus.Dout = '0;
        unique case (bus.Addr)
            2'd0:    bus.Dout = DW'(ctrl);
            2'd1:    bus.Dout = preset;
            2'd2:    bus.Dout = count;
            default: bus.Dout = '0;
        endcase
    end

    assign bus.IRQ = irq_flag & ctrl[3];

endmodule

// File: tb/tb_tc_timer.sv
// Directed bench for tc_timer: register access, one-shot, reload, mask, disable and boundary cases.
module tb_tc_timer;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_bad;

    tc_timer_if bus ();

    tc_timer u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to just after the next active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle write; returns just after the edge that captures it.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.Addr = a;
        bus.Din  = d;
        bus.WE   = 1'b1;
        @(posedge clk);
        #1;
        bus.WE   = 1'b0;
        bus.Din  = '0;
    endtask

    task automatic chk_rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
        bus.Addr = a;
        #1;
        check(tag, bus.Dout, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        check(tag, 32'(bus.IRQ), 32'(exp));
    endtask

    initial begin
        n_chk    = 0;
        n_bad    = 0;
        reset    = 1'b0;
        bus.Addr = 2'd0;
        bus.WE   = 1'b0;
        bus.Din  = '0;
        repeat (2) tick();
        chk_irq("por_irq", 1'b0);
        chk_rd("por_ctrl", 2'd0, 32'h0);
        chk_rd("por_preset", 2'd1, 32'h0);
        reset = 1'b1;

        // Reset mid-count after arbitrary programming
        wr(2'd1, 32'h0000_0002);
        wr(2'd0, 32'h0000_000F);
        tick();
        @(negedge clk);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk_rd("rst_ctrl", 2'd0, 32'h0);
        chk_rd("rst_preset", 2'd1, 32'h0);
        chk_rd("rst_count", 2'd2, 32'h0);
        chk_irq("rst_irq", 1'b0);
        repeat (6) tick();
        chk_irq("rst_no_irq_after", 1'b0);

        // Register map corner cases
        wr(2'd0, 32'hFFFF_FFF0);
        chk_rd("ctrl_upper_ignored", 2'd0, 32'h0);
        wr(2'd1, 32'hA5A5_1234);
        chk_rd("preset_rw", 2'd1, 32'hA5A5_1234);
        wr(2'd2, 32'hDEAD_BEEF);
        wr(2'd3, 32'hDEAD_BEEF);
        chk_rd("count_ro", 2'd2, 32'h0);
        chk_rd("off3_zero", 2'd3, 32'h0);

        // One-shot, PRESET=3: IRQ at E5, latched; En clears at E6
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);
        tick(); tick();
        chk_rd("os_count_e2", 2'd2, 32'd3);
        tick(); tick();
        chk_rd("os_count_e4", 2'd2, 32'd1);
        chk_irq("os_irq_e4", 1'b0);
        tick();
        chk_irq("os_irq_e5", 1'b1);
        chk_rd("os_count_e5", 2'd2, 32'd0);
        tick();
        chk_rd("os_ctrl_e6", 2'd0, 32'h8);
        repeat (3) tick();
        chk_irq("os_irq_held", 1'b1);
        wr(2'd0, 32'h8);
        chk_irq("os_irq_cleared", 1'b0);

        // Mode 01: pulses every 5 cycles with reload, otherwise one latched IRQ
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int e = 1; e <= 15; e++) begin
            tick();
`ifdef TC_AUTO_RELOAD_EN
            chk_irq($sformatf("ar_irq_e%0d", e), (e == 5) || (e == 10) || (e == 15));
            if (e == 7) chk_rd("ar_reload_e7", 2'd2, 32'd3);
`else
            chk_irq($sformatf("ar_irq_e%0d", e), e >= 5);
            if (e == 6) chk_rd("ar_off_ctrl_e6", 2'd0, 32'hA);
`endif
        end
        wr(2'd0, 32'h0);
        repeat (3) tick();

        // Mask: flag sets but IRQ stays low; a CTRL write clears the flag
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        for (int e = 1; e <= 6; e++) begin
            tick();
            chk_irq($sformatf("mask_irq_e%0d", e), 1'b0);
        end
        chk_rd("mask_count", 2'd2, 32'd0);
        chk_rd("mask_ctrl", 2'd0, 32'h0);
        wr(2'd0, 32'h8);
        chk_irq("mask_unmask_irq", 1'b0);
        tick();
        chk_irq("mask_unmask_irq2", 1'b0);

        // Disable mid-count then re-enable
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        repeat (6) tick();
        chk_rd("dis_count_e6", 2'd2, 32'd6);
        wr(2'd0, 32'h0);
        chk_rd("dis_count_e7", 2'd2, 32'd5);
        repeat (3) tick();
        chk_rd("dis_count_frozen", 2'd2, 32'd5);
        chk_irq("dis_irq", 1'b0);
        wr(2'd0, 32'h9);
        tick(); tick();
        chk_rd("dis_reload", 2'd2, 32'd10);
        wr(2'd0, 32'h0);
        repeat (3) tick();

        // PRESET=0 behaves as 1: IRQ at E3
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        tick(); tick();
        chk_irq("p0_irq_e2", 1'b0);
        tick();
        chk_irq("p0_irq_e3", 1'b1);
        chk_rd("p0_count_e3", 2'd2, 32'd0);
        wr(2'd0, 32'h0);
        repeat (3) tick();

        // PRESET rewrite during countdown applies at the next LOAD
        wr(2'd1, 32'd4);
        wr(2'd0, 32'h9);
        tick(); tick();
        chk_rd("pw_count_e2", 2'd2, 32'd4);
        wr(2'd1, 32'd7);
        chk_rd("pw_count_e3", 2'd2, 32'd3);
        tick(); tick();
        chk_rd("pw_count_e5", 2'd2, 32'd1);
        tick();
        chk_irq("pw_irq_e6", 1'b1);
        wr(2'd0, 32'h9);
        chk_irq("pw_irq_clr", 1'b0);
        chk_rd("pw_ctrl_write_wins", 2'd0, 32'h9);
        tick(); tick();
        chk_rd("pw_reload_7", 2'd2, 32'd7);
        wr(2'd0, 32'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
